// File: rtl/cordic_row_rotator.sv
// Iterative CORDIC that rotates a complex row plus its symbol by the
// negative pivot phase; outputs keep the uncompensated CORDIC gain.
module cordic_row_rotator #(
  parameter int WL   = 16,
  parameter int N    = 4,
  parameter int ITER = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WL*N-1:0] Hin_x,
  input  logic [WL*N-1:0] Hin_y,
  input  logic [WL-1:0]   yin_x,
  input  logic [WL-1:0]   yin_y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WL*N-1:0] Hout_x,
  output logic [WL*N-1:0] Hout_y,
  output logic [WL-1:0]   yout_x,
  output logic [WL-1:0]   yout_y
);

  localparam int IW = WL + 2;
  localparam int KW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [KW-1:0] KLAST = KW'(ITER - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ROT  = 2'd1;
  localparam logic [1:0] SAT  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]           st_q, st_d;
  logic [KW-1:0]        k_q, k_d;
  logic signed [IW-1:0] x_q [N+1];
  logic signed [IW-1:0] y_q [N+1];
  logic signed [IW-1:0] x_d [N+1];
  logic signed [IW-1:0] y_d [N+1];
  logic signed [IW-1:0] cx  [N+1];
  logic signed [IW-1:0] cy  [N+1];

  logic [WL*N-1:0] hx_q, hy_q, hx_d, hy_d;
  logic [WL-1:0]   yx_q, yy_q, yx_d, yy_d;

  function automatic logic signed [IW-1:0] sext(input logic [WL-1:0] v);
    return {{2{v[WL-1]}}, v};
  endfunction

  function automatic logic [WL-1:0] sat(input logic signed [IW-1:0] v);
    if ((&v[IW-1:WL-1]) || !(|v[IW-1:WL-1]))
      return v[WL-1:0];
    else if (v[IW-1])
      return {1'b1, {(WL-1){1'b0}}};
    else
      return {1'b0, {(WL-1){1'b1}}};
  endfunction

  assign in_ready  = (st_q == IDLE) && !rst;
  assign out_valid = (st_q == DONE);
  assign Hout_x    = hx_q;
  assign Hout_y    = hy_q;
  assign yout_x    = yx_q;
  assign yout_y    = yy_q;

  // Negative pivot x: 180 degree pre-rotation so CORDIC converges.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      cx[i] = sext(Hin_x[WL*i +: WL]);
      cy[i] = sext(Hin_y[WL*i +: WL]);
    end
    cx[N] = sext(yin_x);
    cy[N] = sext(yin_y);
    if (Hin_x[WL-1]) begin
      for (int i = 0; i <= N; i++) begin
        cx[i] = -cx[i];
        cy[i] = -cy[i];
      end
    end
  end

  always_comb begin
    st_d = st_q;
    k_d  = k_q;
    for (int i = 0; i <= N; i++) begin
      x_d[i] = x_q[i];
      y_d[i] = y_q[i];
    end
    unique case (st_q)
      IDLE: begin
        if (in_valid) begin
          st_d = ROT;
          k_d  = '0;
          for (int i = 0; i <= N; i++) begin
            x_d[i] = cx[i];
            y_d[i] = cy[i];
          end
        end
      end
      ROT: begin
        for (int i = 0; i <= N; i++) begin
          if (y_q[0][IW-1]) begin
            x_d[i] = x_q[i] - (y_q[i] >>> k_q);
            y_d[i] = y_q[i] + (x_q[i] >>> k_q);
          end else begin
            x_d[i] = x_q[i] + (y_q[i] >>> k_q);
            y_d[i] = y_q[i] - (x_q[i] >>> k_q);
          end
        end
        k_d = k_q + KW'(1);
        if (k_q == KLAST) st_d = SAT;
      end
      SAT:  st_d = DONE;
      DONE: if (out_ready) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    hx_d = hx_q;
    hy_d = hy_q;
    yx_d = yx_q;
    yy_d = yy_q;
    if (st_q == SAT) begin
      for (int i = 0; i < N; i++) begin
        hx_d[WL*i +: WL] = sat(x_q[i]);
        hy_d[WL*i +: WL] = sat(y_q[i]);
      end
      hy_d[WL-1:0] = '0;
      yx_d = sat(x_q[N]);
      yy_d = sat(y_q[N]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= IDLE;
      k_q  <= '0;
      hx_q <= '0;
      hy_q <= '0;
      yx_q <= '0;
      yy_q <= '0;
      for (int i = 0; i <= N; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      st_q <= st_d;
      k_q  <= k_d;
      hx_q <= hx_d;
      hy_q <= hy_d;
      yx_q <= yx_d;
      yy_q <= yy_d;
      for (int i = 0; i <= N; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
    end
  end

endmodule
